// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU operation requests in a small FIFO, issues
// each one to a downstream combinational ALU for a single cycle, and holds
// the captured result on a valid/ready response channel.
// Optional feature macro: ALU_SEQ_ILLEGAL_CMD_EN -- commands 101..111 are
// not issued; they are answered directly with rsp_err_out=1 and zero data.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rstn_in,
    // request channel
    input  logic          req_valid_in,
    output logic          req_ready_out,
    input  logic [7:0]    req_a_in,
    input  logic [7:0]    req_b_in,
    input  logic [2:0]    req_cmd_in,
    // downstream ALU
    output logic [7:0]    alu_a_out,
    output logic [7:0]    alu_b_out,
    output logic [2:0]    alu_cmd_out,
    output logic          alu_en_out,
    input  logic [15:0]   alu_d_in,
    // response channel
    output logic          rsp_valid_out,
    input  logic          rsp_ready_in,
    output logic [15:0]   rsp_data_out,
    output logic [2:0]    rsp_cmd_out,
    output logic          rsp_err_out,
    // occupancy
    output logic [CW-1:0] count_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [2:0] cmd;
        logic [7:0] b;
        logic [7:0] a;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          state, state_nx;
    req_t            mem [DEPTH];
    req_t            head, wr_ent, op_q;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            rdy_q;
    logic            push, pop, head_bad;
    logic [15:0]     rsp_data_q;
    logic [2:0]      rsp_cmd_q;

    // rdy_q is low while in reset and for the reset edge itself, so ready
    // comes up one cycle after reset releases; otherwise ready depends only
    // on the registered occupancy, never on a same-cycle pop.
    assign req_ready_out = rdy_q && (count != CW'(DEPTH));
    assign push          = req_valid_in && req_ready_out;
    assign wr_ent        = '{cmd: req_cmd_in, b: req_b_in, a: req_a_in};
    assign head          = mem[rd_ptr];
    assign count_out     = count;

`ifdef ALU_SEQ_ILLEGAL_CMD_EN
    assign head_bad = (head.cmd >= 3'd5);
`else
    assign head_bad = 1'b0;
`endif

    assign alu_a_out     = op_q.a;
    assign alu_b_out     = op_q.b;
    assign alu_cmd_out   = op_q.cmd;
    assign alu_en_out    = (state == ISSUE);
    assign rsp_valid_out = (state == RESP);
    assign rsp_data_out  = rsp_data_q;
    assign rsp_cmd_out   = rsp_cmd_q;

    // FIFO storage; no reset needed, pointers and count qualify contents
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= wr_ent;
    end

    // FIFO pointers, occupancy and the post-reset ready enable
    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!rstn_in) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and pop decision; pops only look at occupancy at cycle start
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    state_nx = head_bad ? RESP : ISSUE;
                end
            end
            ISSUE: state_nx = RESP;
            RESP: begin
                if (rsp_ready_in) begin
                    if (count != '0) begin
                        pop      = 1'b1;
                        state_nx = head_bad ? RESP : ISSUE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand and response registers; ALU drive only changes when a legal
    // op is popped, so it holds its last value outside ISSUE
    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_cmd_q  <= '0;
        end else begin
            if (pop && !head_bad) op_q <= head;
            if (state == ISSUE) begin
                rsp_data_q <= alu_d_in;
                rsp_cmd_q  <= op_q.cmd;
            end else if (pop && head_bad) begin
                rsp_data_q <= '0;
                rsp_cmd_q  <= head.cmd;
            end
        end
    end

`ifdef ALU_SEQ_ILLEGAL_CMD_EN
    logic err_q;

    // Error flag: set for a directly-answered illegal command
    always_ff @(posedge clk_in) begin
        if (!rstn_in)             err_q <= 1'b0;
        else if (state == ISSUE)  err_q <= 1'b0;
        else if (pop && head_bad) err_q <= 1'b1;
    end

    assign rsp_err_out = err_q;
`else
    assign rsp_err_out = 1'b0;
`endif

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning request FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter CW, default $clog2(DEPTH)+1, meaning width of count_out.
REQ-003 The block SHALL have port clk_in, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rstn_in, input, 1; reset is synchronous and active-low.
REQ-005 The block SHALL have ports req_valid_in input 1, req_ready_out output 1, req_a_in input 8, req_b_in input 8, req_cmd_in input 3: the operation request channel.
REQ-006 The block SHALL have ports alu_a_out output 8, alu_b_out output 8, alu_cmd_out output 3, alu_en_out output 1, alu_d_in input 16: the drive and result of the downstream combinational ALU (cmd 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT).
REQ-007 The block SHALL have ports rsp_valid_out output 1, rsp_ready_in input 1, rsp_data_out output 16, rsp_cmd_out output 3, rsp_err_out output 1: the result channel.
REQ-008 The block SHALL have port count_out, output, CW, giving the current FIFO occupancy.

Function
REQ-009 A request SHALL be written into the FIFO on a rising edge where req_valid_in and req_ready_out are both 1.
REQ-010 req_ready_out SHALL equal (count_out != DEPTH), derived from registered state only, with no combinational path from a same-cycle pop; push is refused when full, even if a pop occurs that cycle.
REQ-011 The FSM SHALL have states IDLE, ISSUE, and RESP.
REQ-012 In IDLE with FIFO non-empty at cycle start, the FSM SHALL pop the head into operand registers and go to ISSUE; when empty it SHALL stay in IDLE, and a same-cycle push is not visible until the next cycle.
REQ-013 In ISSUE, alu_en_out SHALL be 1 for exactly one cycle, with alu_a/b/cmd_out driven from the operand registers; at the end of that cycle the FSM SHALL capture alu_d_in into rsp_data_out, the command into rsp_cmd_out, and go to RESP.
REQ-014 In RESP, rsp_valid_out SHALL be 1, and rsp_data/cmd/err_out SHALL be held stable until the rsp_valid_out and rsp_ready_in handshake.
REQ-015 On that handshake, the FSM SHALL pop and go to ISSUE if the FIFO is non-empty; otherwise it SHALL go to IDLE.
REQ-016 Latency SHALL be fixed: a request accepted at edge N into an empty, idle block gives rsp_valid_out=1 after edge N+2; sustained throughput with rsp_ready_in=1 is one result per 2 cycles.
REQ-017 alu_en_out SHALL be 0 outside ISSUE, and alu_a/b/cmd_out SHALL hold their last values.
REQ-018 For NOT, req_b_in SHALL still be forwarded unchanged; the ALU ignores it.
REQ-019 count_out SHALL increment on push-only, decrement on pop-only, and be unchanged on simultaneous push and pop; FIFO pointers wrap modulo DEPTH.
REQ-020 rsp_data_out SHALL be the 16-bit alu_d_in unmodified, with no width truncation or sign handling.

Reset
REQ-021 While rstn_in=0 at a rising edge, the FSM SHALL go to IDLE, FIFO pointers and count_out go to 0, and all outputs go to 0, including req_ready_out.
REQ-022 req_ready_out SHALL rise in the first cycle after reset deasserts.
REQ-023 Reset asserted mid-operation, in ISSUE or RESP, SHALL discard the in-flight op and all queued requests; no response is produced for them.

Configuration
REQ-024 Macro ALU_SEQ_ILLEGAL_CMD_EN defined: a popped cmd in 101..111 SHALL skip ISSUE (alu_en_out stays 0) and go directly to RESP with rsp_data_out=16'h0000, rsp_err_out=1, and rsp_cmd_out equal to the command.
REQ-025 Macro ALU_SEQ_ILLEGAL_CMD_EN undefined: all commands SHALL be issued normally, and rsp_err_out SHALL be tied to 0.

Verification
REQ-026 ADD a=12, b=10 into an idle block -> alu_en_out high exactly one cycle, rsp_valid_out after edge N+2, rsp_data_out=22, rsp_cmd_out=000.
REQ-027 Back-to-back SUB 15,10; AND 2,3; OR 4,9; NOT 5 with rsp_ready_in=1 -> responses in order with results 5, 2, 13, then the ALU's NOT result for 5, spaced 2 cycles apart.
REQ-028 rsp_ready_in=0 and 6 pushes -> first op held in RESP, count_out reaches 4, req_ready_out=0, 6th request stalls; releasing rsp_ready_in drains all 6 in order.
REQ-029 rstn_in=0 for one edge while in RESP with 3 queued -> rsp_valid_out=0, count_out=0, req_ready_out=0, then 1 the next cycle; no stale response appears.
REQ-030 With ALU_SEQ_ILLEGAL_CMD_EN, cmd=101 -> rsp_err_out=1, rsp_data_out=0, alu_en_out never asserted; without the macro -> alu_en_out pulses and rsp_err_out=0.
